// File: rtl/tx_packet_gate.sv
// Packet gate in front of a 10GbE TX core. Each packet is either forwarded with
// one cycle of latency or dropped. The block also enforces packet length and tracks payload-ID continuity.
module tx_packet_gate #(
  parameter int PKT_WORDS = 1025
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        cnt_rst,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  input  logic        in_eod,
  input  logic        tx_afull,
  input  logic        tx_overflow,
  output logic [63:0] tx_data,
  output logic        tx_valid,
  output logic        tx_eod,
  output logic [31:0] sent_cnt,
  output logic [31:0] drop_cnt,
  output logic [15:0] len_err_cnt,
  output logic [15:0] seq_err_cnt,
  output logic        busy
);

  localparam int WCW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [WCW-1:0] LAST_W = WCW'(PKT_WORDS - 1);

  typedef enum logic [1:0] {IDLE, PASS, DROP, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [63:0]     tx_data_q;
  logic            tx_valid_q, tx_eod_q;
  logic [63:0]     prev_id_q;
  logic            id_vld_q;
  logic [31:0]     sent_cnt_q, drop_cnt_q;
  logic [15:0]     len_err_cnt_q, seq_err_cnt_q;

  // Per-word decode. "mode" is the state that owns the current word. A start
  // word in IDLE is handled by the chosen PASS/DROP state in the same cycle.
  state_t          mode;
  logic            start, fwd, in_pkt, at_last, pkt_end, len_bad, seq_bad;
  logic [WCW-1:0]  cur_w;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    mode    = state_q;
    start   = (state_q == IDLE) && in_valid;
    if (start) mode = (enable && !tx_afull && !tx_overflow) ? PASS : DROP;
    cur_w   = start ? '0 : wcnt_q;
    at_last = (cur_w == LAST_W);
    in_pkt  = in_valid && ((mode == PASS) || (mode == DROP));
    fwd     = in_valid && (mode == PASS);
    pkt_end = in_pkt && (in_eod || at_last);
    len_bad = pkt_end && !(in_eod && at_last);
    seq_bad = start && id_vld_q && (in_data != prev_id_q + 64'd1);

    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (pkt_end) begin
      // An overrun without eod keeps discarding words until the upstream eod arrives.
      state_d = in_eod ? IDLE : FLUSH;
      wcnt_d  = '0;
    end else if (in_pkt) begin
      state_d = mode;
      wcnt_d  = cur_w + 1'b1;
    end else if ((state_q == FLUSH) && in_valid && in_eod) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wcnt_q        <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      tx_eod_q      <= 1'b0;
      prev_id_q     <= '0;
      id_vld_q      <= 1'b0;
      sent_cnt_q    <= '0;
      drop_cnt_q    <= '0;
      len_err_cnt_q <= '0;
      seq_err_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      tx_valid_q <= fwd;
      tx_data_q  <= fwd ? in_data : '0;
      tx_eod_q   <= fwd && (in_eod || at_last);

      if (start) begin
        prev_id_q <= in_data;
        id_vld_q  <= 1'b1;
      end

      if (cnt_rst) begin
        sent_cnt_q    <= '0;
        drop_cnt_q    <= '0;
        len_err_cnt_q <= '0;
        seq_err_cnt_q <= '0;
      end else begin
        if (pkt_end && (mode == PASS)) sent_cnt_q    <= sent_cnt_q + 32'd1;
        if (pkt_end && (mode == DROP)) drop_cnt_q    <= drop_cnt_q + 32'd1;
        if (len_bad)                   len_err_cnt_q <= len_err_cnt_q + 16'd1;
        if (seq_bad)                   seq_err_cnt_q <= seq_err_cnt_q + 16'd1;
      end
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign tx_eod      = tx_eod_q;
  assign sent_cnt    = sent_cnt_q;
  assign drop_cnt    = drop_cnt_q;
  assign len_err_cnt = len_err_cnt_q;
  assign seq_err_cnt = seq_err_cnt_q;
  assign busy        = (state_q != IDLE);

endmodule
